mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port synchronous memory between the instruction-fetch port and the load/store port of the multi-cycle RISC-V core. Each requester uses a req/ready handshake. The arbiter grants one access at a time, drives the memory strobes for exactly one cycle and returns read data with a one-cycle `ready` pulse. It sits between the core's FETCH_INSTR and load/store states and the `MEM` array, so fetch and data can later share a single RAM.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width of the requester ports.
- `ROUND_ROBIN`, default 1:
  - 1: alternate grants when both ports request.
  - 0: fixed priority, D over I.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_req` in 1: fetch request, level.
- `i_addr` in ADDR_WIDTH: fetch byte address; bits [1:0] ignored.
- `i_rdata` out 32: fetched word; valid only while `i_ready`=1.
- `i_ready` out 1: one-cycle completion pulse for the fetch port.
- `d_req` in 1: data request, level.
- `d_addr` in ADDR_WIDTH: data byte address; bits [1:0] ignored.
- `d_wmask` in 4: byte write enables; 4'b0000 means read.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data; valid only while `d_ready`=1 for a read.
- `d_ready` out 1: one-cycle completion pulse for the data port.
- `mem_addr` out ADDR_WIDTH-2: word address to the memory.
- `mem_rstrb` out 1: read strobe; the memory returns `mem_rdata` in the next cycle.
- `mem_wmask` out 4: byte write enables; the memory writes at the clock edge that ends the strobe cycle.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, one cycle after `mem_rstrb`.
- `busy` out 1: high in ACCESS and RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Arbitration runs in IDLE and in RESP. In RESP the current owner's `req` is treated as consumed and is not a candidate.
- Grant rule:
  - Only one candidate: it wins.
  - Both candidates, ROUND_ROBIN=1: the port not granted last wins. `last_grant` resets to D, so I wins the first tie.
  - Both candidates, ROUND_ROBIN=0: D wins.
- On grant:
  - Register `owner`.
  - Register `mem_addr` = addr[ADDR_WIDTH-1:2].
  - For I: `mem_rstrb`=1, `mem_wmask`=0.
  - For D: if `d_wmask`==0, `mem_rstrb`=1 and `mem_wmask`=0; otherwise `mem_rstrb`=0, `mem_wmask`=`d_wmask`, `mem_wdata`=`d_wdata`.
  - Go to ACCESS and update `last_grant`.
- ACCESS: the strobes are high for this single cycle only. Go to RESP.
- RESP:
  - Strobes are 0. The owner's `ready` is 1.
  - `i_rdata` and `d_rdata` are continuous copies of `mem_rdata`.
  - Writes also pass through RESP and pulse `d_ready`; `d_rdata` is don't-care for writes.
  - If another candidate is pending, grant it and go to ACCESS; otherwise go to IDLE.
- Requester rules:
  - Hold `req`, address, `wmask` and `wdata` stable until the cycle of `ready`.
  - `req` high in the cycle after `ready` is a new request.
  - Dropping `req` before `ready` is illegal; the access completes anyway.
- Only one of `i_ready` and `d_ready` is high in any cycle.

## Timing
- Reset values: `i_ready`, `d_ready`, `mem_rstrb`, `mem_wmask`, `busy` = 0; `mem_addr`, `mem_wdata` = 0; `last_grant` = D; `owner` = I.
- All outputs are registered except `i_rdata`/`d_rdata`, which are wired to `mem_rdata`.
- Latency, for a request sampled in IDLE at edge N:
  - ACCESS occupies cycle N+1 with the strobes high.
  - RESP occupies cycle N+2 with `ready` high.
  - Total: 2 cycles from the sampling edge to `ready`.
- Back-to-back accesses from alternating ports: one `ready` every 2 cycles.
- A repeat access from the same port: IDLE is re-entered, so one `ready` every 3 cycles.
- Reset asserted at any time:
  - Outputs clear immediately and the FSM returns to IDLE.
  - A write whose ACCESS cycle has not reached its closing edge is not performed.
  - No `ready` is issued for the aborted access.
- Reset deasserted: arbitration resumes at the first rising edge with `reset`=0.

## Test plan
- **Single fetch.** Memory word 2 = 0x00000013; `i_req`=1, `i_addr`=0x8 at edge 0.
  - `mem_rstrb`=1 and `mem_addr`=2 in cycle 1.
  - `i_ready`=1 and `i_rdata`=0x00000013 in cycle 2 only.
- **Write then read-back.** D write to 0x10, `wmask`=4'b0011, `wdata`=0xAABBCCDD, over old value 0x11223344; then a D read of 0x10.
  - Write: `mem_wmask`=0011 for one cycle.
  - Read returns 0x1122CCDD with `d_ready` 3 cycles after the write's `d_ready`.
- **Simultaneous requests, ROUND_ROBIN=1.** `i_req` and `d_req` both held continuously.
  - Grant order I, D, I, D.
  - `ready` pulses every 2 cycles; never both high.
- **Fixed priority, ROUND_ROBIN=0.** Both requesters raise `req` in the same cycle.
  - D is served first; I's `ready` comes 2 cycles after D's.
- **Reset mid-access.** Assert `reset` during the ACCESS cycle of a write to 0x20.
  - Memory at 0x20 is unchanged, no `d_ready`, all outputs 0 immediately.
  - After release, a new request completes normally.
- **Address low bits.** `i_addr`=0x0000000B gives `mem_addr`=2; bits [1:0] have no effect.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port synchronous memory.
// One access at a time: a grant cycle, a one-cycle strobe (ACCESS), then a one-cycle ready (RESP).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_wmask,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_ready,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_rstrb,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
    typedef enum logic {PortI = 1'b0, PortD = 1'b1} port_e;

    state_e                state_q, state_d;
    port_e                 owner_q, owner_d;
    port_e                 last_q, last_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic                  rstrb_q, rstrb_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  busy_q, busy_d;

    logic i_cand, d_cand, pick_d;

    // In RESP the owner's request has just been served, so it is not a candidate again.
    assign i_cand = i_req && !(state_q == StResp && owner_q == PortI);
    assign d_cand = d_req && !(state_q == StResp && owner_q == PortD);

    always_comb begin
        if (ROUND_ROBIN) begin
            pick_d = d_cand && (!i_cand || last_q == PortI);
        end else begin
            pick_d = d_cand;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = 4'b0000;
        rstrb_d   = 1'b0;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;

        unique case (state_q)
            StAccess: begin
                state_d   = StResp;
                i_ready_d = (owner_q == PortI);
                d_ready_d = (owner_q == PortD);
            end
            StIdle, StResp: begin
                if (i_cand || d_cand) begin
                    state_d = StAccess;
                    if (pick_d) begin
                        owner_d = PortD;
                        last_d  = PortD;
                        addr_d  = d_addr[ADDR_WIDTH-1:2];
                        if (d_wmask == 4'b0000) begin
                            rstrb_d = 1'b1;
                        end else begin
                            wmask_d = d_wmask;
                            wdata_d = d_wdata;
                        end
                    end else begin
                        owner_d = PortI;
                        last_d  = PortI;
                        addr_d  = i_addr[ADDR_WIDTH-1:2];
                        rstrb_d = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // Async reset drops the strobes at once, so a write still in ACCESS never commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= PortI;
            last_q    <= PortD;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= 4'b0000;
            rstrb_q   <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rstrb_q   <= rstrb_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign mem_rstrb = rstrb_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = busy_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance backed by a memory model,
// plus a fixed-priority instance used only for grant-order timing.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;

    logic          clock;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_wmask;
    logic [31:0]   d_wdata;

    logic [31:0]   i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_rstrb, busy;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_wmask;

    logic [31:0]   i_rdata_f, d_rdata_f, mem_wdata_f;
    logic          i_ready_f, d_ready_f, mem_rstrb_f, busy_f;
    logic [AW-3:0] mem_addr_f;
    logic [3:0]    mem_wmask_f;

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int n_checks;
    int n_fails;

    mem_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1'b0)) dut_fixed (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_f), .i_ready(i_ready_f),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdata(d_rdata_f), .d_ready(d_ready_f),
        .mem_addr(mem_addr_f), .mem_rstrb(mem_rstrb_f), .mem_wmask(mem_wmask_f),
        .mem_wdata(mem_wdata_f), .mem_rdata(32'h0), .busy(busy_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous memory: read data one cycle after the strobe, byte writes.
    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            if (mem_rstrb) mem_rdata <= mem[mem_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        step();
        pl_en = 1'b0;
    endtask

    task automatic chk_outputs_clear(input string tag);
        chk({tag, "_i_ready"}, {31'b0, i_ready}, 32'h0);
        chk({tag, "_d_ready"}, {31'b0, d_ready}, 32'h0);
        chk({tag, "_rstrb"}, {31'b0, mem_rstrb}, 32'h0);
        chk({tag, "_wmask"}, {28'b0, mem_wmask}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_addr   = '0;
        d_wmask  = 4'b0000;
        d_wdata  = '0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;

        step();
        preload(8'd2, 32'h0000_0013);
        preload(8'd4, 32'h1122_3344);
        preload(8'd8, 32'hCAFE_F00D);
        chk_outputs_clear("reset");
        reset = 1'b0;
        step();

        // Single fetch from byte address 0x8.
        i_req  = 1'b1;
        i_addr = 32'h8;
        step();
        chk("fetch_rstrb", {31'b0, mem_rstrb}, 32'h1);
        chk("fetch_addr", mem_addr, 32'h2);
        chk("fetch_wmask", {28'b0, mem_wmask}, 32'h0);
        chk("fetch_busy", {31'b0, busy}, 32'h1);
        chk("fetch_early_ready", {31'b0, i_ready}, 32'h0);
        step();
        chk("fetch_ready", {31'b0, i_ready}, 32'h1);
        chk("fetch_rdata", i_rdata, 32'h0000_0013);
        chk("fetch_no_d_ready", {31'b0, d_ready}, 32'h0);
        chk("fetch_resp_rstrb", {31'b0, mem_rstrb}, 32'h0);
        i_req = 1'b0;
        step();
        chk("fetch_ready_once", {31'b0, i_ready}, 32'h0);
        chk("fetch_idle", {31'b0, busy}, 32'h0);

        // Partial write to 0x10, then read it back from the same port.
        d_req   = 1'b1;
        d_addr  = 32'h10;
        d_wmask = 4'b0011;
        d_wdata = 32'hAABB_CCDD;
        step();
        chk("wr_wmask", {28'b0, mem_wmask}, 32'h3);
        chk("wr_rstrb", {31'b0, mem_rstrb}, 32'h0);
        chk("wr_wdata", mem_wdata, 32'hAABB_CCDD);
        chk("wr_addr", mem_addr, 32'h4);
        step();
        chk("wr_ready", {31'b0, d_ready}, 32'h1);
        chk("wr_wmask_one_cycle", {28'b0, mem_wmask}, 32'h0);
        d_wmask = 4'b0000;
        d_wdata = 32'h0;
        step();
        chk("rd_gap1", {31'b0, d_ready}, 32'h0);
        step();
        chk("rd_rstrb", {31'b0, mem_rstrb}, 32'h1);
        chk("rd_gap2", {31'b0, d_ready}, 32'h0);
        step();
        chk("rd_ready", {31'b0, d_ready}, 32'h1);
        chk("rd_rdata", d_rdata, 32'h1122_CCDD);
        chk("rd_mem", mem[4], 32'h1122_CCDD);
        d_req = 1'b0;
        step();

        // Round robin with both requests held: ready pulses I, D, I, D every two cycles.
        i_req  = 1'b1;
        i_addr = 32'h8;
        d_req  = 1'b1;
        d_addr = 32'h10;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rr_i_ready_%0d", k), {31'b0, i_ready},
                {31'b0, (k == 2 || k == 6)});
            chk($sformatf("rr_d_ready_%0d", k), {31'b0, d_ready},
                {31'b0, (k == 4 || k == 8)});
            if (k == 2) chk("rr_i_rdata", i_rdata, 32'h0000_0013);
            if (k == 4) chk("rr_d_rdata", d_rdata, 32'h1122_CCDD);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        chk("rr_idle", {31'b0, busy}, 32'h0);

        // Fixed priority: D first, I two cycles later.
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        step();
        chk("fp_access_no_ready", {30'b0, i_ready_f, d_ready_f}, 32'h0);
        step();
        chk("fp_d_first", {30'b0, i_ready_f, d_ready_f}, 32'h1);
        d_req = 1'b0;
        step();
        chk("fp_gap", {30'b0, i_ready_f, d_ready_f}, 32'h0);
        step();
        chk("fp_i_second", {30'b0, i_ready_f, d_ready_f}, 32'h2);
        i_req = 1'b0;
        step();

        // Reset during the ACCESS cycle of a full-word write to 0x20.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        d_req   = 1'b1;
        d_addr  = 32'h20;
        d_wmask = 4'b1111;
        d_wdata = 32'hDEAD_BEEF;
        step();
        chk("abort_wmask", {28'b0, mem_wmask}, 32'hF);
        #1 reset = 1'b1;
        #1 chk_outputs_clear("abort");
        d_req   = 1'b0;
        d_wmask = 4'b0000;
        step();
        chk("abort_no_ready", {31'b0, d_ready}, 32'h0);
        step();
        chk("abort_mem_kept", mem[8], 32'hCAFE_F00D);
        reset = 1'b0;
        step();
        chk("abort_still_no_ready", {31'b0, d_ready}, 32'h0);
        chk("abort_idle", {31'b0, busy}, 32'h0);
        d_req = 1'b1;
        step();
        chk("recover_rstrb", {31'b0, mem_rstrb}, 32'h1);
        chk("recover_addr", mem_addr, 32'h8);
        step();
        chk("recover_ready", {31'b0, d_ready}, 32'h1);
        chk("recover_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        step();

        // Address bits [1:0] are ignored.
        i_req  = 1'b1;
        i_addr = 32'h0000_000B;
        step();
        chk("lowbits_addr", mem_addr, 32'h2);
        step();
        chk("lowbits_ready", {31'b0, i_ready}, 32'h1);
        chk("lowbits_rdata", i_rdata, 32'h0000_0013);
        i_req = 1'b0;
        step();
        chk("lowbits_idle", {31'b0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
